// File: rtl/hazard_stall_unit_pkg.sv
// Shared CPU widths, multiplier defaults and small helpers for the
// pipeline hazard logic.
package hazard_stall_unit_pkg;

  localparam int REG_W       = 5;
  localparam int MUL_LAT_DEF = 4;
  localparam int BUSY_W      = 4;   // holds MUL_LAT-1 for MUL_LAT up to 16
  localparam int STALL_CNT_W = 16;

  typedef logic [REG_W-1:0]       reg_idx_t;
  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  typedef struct packed {
    logic stall;
    logic bubble;
    logic ex_hold;
  } hz_ctl_t;

  function automatic stall_cnt_t sat_inc(input stall_cnt_t v);
    return (&v) ? v : v + stall_cnt_t'(1);
  endfunction

endpackage

// File: rtl/mul_busy_timer.sv
// Multiplier occupancy down-counter: loads LOAD_VAL on start, busy while nonzero.
module mul_busy_timer
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned LOAD_VAL = MUL_LAT_DEF - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  logic [BUSY_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= BUSY_W'(LOAD_VAL);
    end else if (count != '0) begin
      count <= count - BUSY_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/reg_eq_check.sv
// Gated register-index compare: hit when enabled and both indices match.
module reg_eq_check
  import hazard_stall_unit_pkg::*;
(
  input  logic             en,
  input  logic [REG_W-1:0] a,
  input  logic [REG_W-1:0] b,
  output logic             hit
);

  assign hit = en & (a == b);

endmodule

// File: rtl/zero_check.sv
// Flags the hardwired zero register index.
module zero_check
  import hazard_stall_unit_pkg::*;
(
  input  logic [REG_W-1:0] val,
  output logic             is_zero
);

  assign is_zero = (val == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use and multi-cycle multiply interlock; control outputs are combinational
// from tracked state and the current ID instruction.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rs2,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rs2,
  input  logic [REG_W-1:0]       id_rd,
  input  logic                   id_is_load,
  input  logic                   id_is_mul,
  input  logic                   flush,
  output logic                   stall,
  output logic                   bubble,
  output logic                   ex_hold,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic       issue;
  logic       ld_pending;
  reg_idx_t   ld_rd;
  logic       rs_hit;
  logic       rs2_hit;
  logic       rd_zero;
  logic       mul_busy;
  logic       load_use;
  hz_ctl_t    ctl;

  reg_eq_check u_rs_eq  (.en(id_uses_rs),  .a(id_rs),  .b(ld_rd), .hit(rs_hit));
  reg_eq_check u_rs2_eq (.en(id_uses_rs2), .a(id_rs2), .b(ld_rd), .hit(rs2_hit));
  zero_check   u_rd_zero (.val(id_rd), .is_zero(rd_zero));

  mul_busy_timer #(.LOAD_VAL(MUL_LAT - 1)) u_mul_busy_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (issue & id_is_mul),
    .busy  (mul_busy)
  );

  assign load_use = ld_pending & id_valid & ~flush & (rs_hit | rs2_hit);

  // A busy multiplier masks any load-use hazard; the load-use check only
  // matters again once the multiply has drained.
  assign ctl.stall   = mul_busy | load_use;
  assign ctl.bubble  = ~mul_busy & load_use;
  assign ctl.ex_hold = mul_busy;

  assign stall   = ctl.stall;
  assign bubble  = ctl.bubble;
  assign ex_hold = ctl.ex_hold;

  assign issue = id_valid & ~flush & ~ctl.stall;

  // Loads to x0 never arm the tracker, so x0 can never look like a hazard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_pending   <= 1'b0;
      ld_rd        <= '0;
      stall_cycles <= '0;
    end else begin
      ld_pending <= issue & id_is_load & ~rd_zero;
      if (issue & id_is_load & ~rd_zero) begin
        ld_rd <= id_rd;
      end
      if (ctl.stall) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scenario bench for hazard_stall_unit: MUL_LAT=4 instance for interlock
// behaviour, MUL_LAT=16 instance for stall counter saturation.
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rs2;
  logic        id_uses_rs;
  logic        id_uses_rs2;
  logic [4:0]  id_rd;
  logic        id_is_load;
  logic        id_is_mul;
  logic        flush;
  logic        stall;
  logic        bubble;
  logic        ex_hold;
  logic [15:0] stall_cycles;

  logic        valid_b;
  logic        mul_b;
  logic        load_b;
  logic        stall_b;
  logic        bubble_b;
  logic        ex_hold_b;
  logic [15:0] stall_cycles_b;

  int checks = 0;
  int errors = 0;
  int exp_sc = 0;

  typedef struct {
    string      name;
    logic [2:0] v;
  } exp_t;

  exp_t exp_q[$];

  hazard_stall_unit #(.MUL_LAT(4)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs2       (id_rs2),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .id_is_load   (id_is_load),
    .id_is_mul    (id_is_mul),
    .flush        (flush),
    .stall        (stall),
    .bubble       (bubble),
    .ex_hold      (ex_hold),
    .stall_cycles (stall_cycles)
  );

  hazard_stall_unit #(.MUL_LAT(16)) u_dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (valid_b),
    .id_rs        (id_rs),
    .id_rs2       (id_rs2),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .id_is_load   (load_b),
    .id_is_mul    (mul_b),
    .flush        (flush),
    .stall        (stall_b),
    .bubble       (bubble_b),
    .ex_hold      (ex_hold_b),
    .stall_cycles (stall_cycles_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rs2,
                        input logic urs, input logic urs2, input logic [4:0] rd,
                        input logic ld, input logic mul, input logic fl);
    id_valid    = v;
    id_rs       = rs;
    id_rs2      = rs2;
    id_uses_rs  = urs;
    id_uses_rs2 = urs2;
    id_rd       = rd;
    id_is_load  = ld;
    id_is_mul   = mul;
    flush       = fl;
  endtask

  // Push the expected {stall,bubble,ex_hold}, sample mid-cycle, pop and compare,
  // then advance to just after the next rising edge.
  task automatic step(input string nm, input logic es, input logic eb, input logic eh);
    exp_t e;
    exp_q.push_back('{name: nm, v: {es, eb, eh}});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({stall, bubble, ex_hold} !== e.v) begin
      errors++;
      $display("FAIL %s stall/bubble/ex_hold got %b expected %b", e.name,
               {stall, bubble, ex_hold}, e.v);
    end
    if (e.v[2] && exp_sc < 65535) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n   = 1'b0;
    valid_b = 1'b0;
    mul_b   = 1'b0;
    load_b  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    exp_sc = 0;
    checks++;
    if (stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall_cycles got %0d expected 0", stall_cycles);
    end
    step("reset_outputs", 0, 0, 0);
  endtask

  task automatic check_sc(input string nm);
    checks++;
    if (stall_cycles !== 16'(exp_sc)) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d expected %0d", nm, stall_cycles, exp_sc);
    end
  endtask

  task automatic test_load_use;
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);  step("ld5_issue", 0, 0, 0);
    set_id(1, 5, 0, 1, 0, 6, 0, 0, 0);  step("ld5_use", 1, 1, 0);
    step("ld5_release", 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);  step("ld5_idle", 0, 0, 0);
    check_sc("ld5_stall_cycles");
    // rs2 match, gated compares, and a non-matching register
    set_id(1, 0, 0, 0, 0, 9, 1, 0, 0);  step("ld9_issue", 0, 0, 0);
    set_id(1, 3, 9, 0, 1, 10, 0, 0, 0); step("ld9_rs2_use", 1, 1, 0);
    step("ld9_release", 0, 0, 0);
    set_id(1, 0, 0, 0, 0, 9, 1, 0, 0);  step("ld9b_issue", 0, 0, 0);
    set_id(1, 9, 9, 0, 0, 10, 0, 0, 0); step("ld9_unused_regs", 0, 0, 0);
    set_id(1, 0, 0, 0, 0, 12, 1, 0, 0); step("ld12_issue", 0, 0, 0);
    set_id(1, 13, 11, 1, 1, 1, 0, 0, 0); step("ld12_no_match", 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    set_id(1, 0, 0, 0, 0, 8, 1, 0, 0);  step("b2b_ld8", 0, 0, 0);
    set_id(1, 8, 0, 1, 0, 11, 1, 0, 0); step("b2b_ld11_stall", 1, 1, 0);
    step("b2b_ld11_issue", 0, 0, 0);
    set_id(1, 0, 11, 0, 1, 2, 0, 0, 0); step("b2b_use11_stall", 1, 1, 0);
    step("b2b_use11_issue", 0, 0, 0);
    check_sc("b2b_stall_cycles");
  endtask

  task automatic test_load_x0;
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 0);  step("ldx0_issue", 0, 0, 0);
    set_id(1, 0, 0, 1, 1, 4, 0, 0, 0);  step("ldx0_use", 0, 0, 0);
  endtask

  task automatic test_flush;
    set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);  step("ld7_issue", 0, 0, 0);
    set_id(1, 7, 0, 1, 0, 2, 0, 0, 1);  step("ld7_flushed_use", 0, 0, 0);
    set_id(1, 7, 0, 1, 0, 2, 0, 0, 0);  step("ld7_after_flush", 0, 0, 0);
  endtask

  task automatic test_mul;
    int base;
    base = exp_sc;
    set_id(1, 0, 0, 0, 0, 3, 0, 1, 0);  step("mul_issue", 0, 0, 0);
    set_id(1, 3, 3, 1, 1, 4, 0, 0, 0);  step("mul_busy1", 1, 0, 1);
    set_id(1, 3, 3, 1, 1, 4, 0, 0, 1);  step("mul_busy2_flush", 1, 0, 1);
    set_id(1, 3, 3, 1, 1, 4, 0, 0, 0);  step("mul_busy3", 1, 0, 1);
    step("mul_done", 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cycles !== 16'(base + 3)) begin
      errors++;
      $display("FAIL mul_stall_cycles_delta got %0d expected %0d", stall_cycles, base + 3);
    end
  endtask

  task automatic test_ld_then_mul;
    set_id(1, 0, 0, 0, 0, 4, 1, 0, 0);  step("ldmul_ld4", 0, 0, 0);
    set_id(1, 4, 0, 1, 0, 6, 0, 1, 0);  step("ldmul_hazard", 1, 1, 0);
    step("ldmul_mul_issue", 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("ldmul_busy1", 1, 0, 1);
    step("ldmul_busy2", 1, 0, 1);
    step("ldmul_busy3", 1, 0, 1);
    step("ldmul_done", 0, 0, 0);
    check_sc("ldmul_stall_cycles");
  endtask

  task automatic test_reset_mid_mul;
    set_id(1, 0, 0, 0, 0, 1, 0, 1, 0);  step("rmul_issue", 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);  step("rmul_busy1", 1, 0, 1);
    rst_n = 1'b0;                       step("rmul_busy2_in_reset", 1, 0, 1);
    exp_sc = 0;
    rst_n = 1'b1;
    check_sc("rmul_stall_cycles_cleared");
    step("rmul_after_reset", 0, 0, 0);
  endtask

  task automatic test_saturation;
    int stalls;
    int bad;
    logic es;
    stalls = 0;
    bad    = 0;
    valid_b = 1'b1;
    mul_b   = 1'b1;
    for (int k = 0; k < 80000 && stalls < 70000; k++) begin
      @(negedge clk);
      es = (k % 16) != 0;
      if (stalls == 1000) begin
        checks++;
        if (stall_cycles_b !== 16'd1000) begin
          errors++;
          $display("FAIL sat_midpoint stall_cycles got %0d expected 1000", stall_cycles_b);
        end
      end
      if (stall_b !== es || ex_hold_b !== es || bubble_b !== 1'b0) bad++;
      if (es) stalls++;
    end
    @(posedge clk);
    #1;
    valid_b = 1'b0;
    mul_b   = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sat_mul16_pattern cycles_wrong %0d expected 0", bad);
    end
    checks++;
    if (stall_cycles_b !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold stall_cycles got %h expected ffff after %0d stalls",
               stall_cycles_b, stalls);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_load_x0();
    test_flush();
    test_mul();
    test_ld_then_mul();
    test_reset_mid_mul();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning multiplier occupancy of EX in cycles (legal range 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port id_valid  input  1  a valid instruction is in ID.
REQ-005 SHALL have port id_rs  input  5  ID source register 1.
REQ-006 SHALL have port id_rs2  input  5  ID source register 2.
REQ-007 SHALL have port id_uses_rs  input  1  ID instruction reads id_rs.
REQ-008 SHALL have port id_uses_rs2  input  1  ID instruction reads id_rs2.
REQ-009 SHALL have port id_rd  input  5  ID destination register.
REQ-010 SHALL have port id_is_load  input  1  ID instruction is a load.
REQ-011 SHALL have port id_is_mul  input  1  ID instruction is a multi-cycle multiply.
REQ-012 SHALL have port flush  input  1  branch flush; kills the ID instruction this cycle.
REQ-013 SHALL have port stall  output  1  hold PC and IF/ID register.
REQ-014 SHALL have port bubble  output  1  load NOP into ID/EX this cycle.
REQ-015 SHALL have port ex_hold  output  1  hold ID/EX and EX state (multiply in progress).
REQ-016 SHALL have port stall_cycles  output  16  saturating count of cycles with stall=1.

Function
REQ-017 SHALL define issue = id_valid & ~flush & ~stall; only issued instructions update tracking state.
REQ-018 SHALL, on issue with id_is_load=1 and id_rd!=0, set ld_pending=1 and ld_rd=id_rd next cycle; otherwise clear ld_pending next cycle.
REQ-019 SHALL assert load-use hazard when ld_pending & id_valid & ~flush & ((id_uses_rs & id_rs==ld_rd) | (id_uses_rs2 & id_rs2==ld_rd)).
REQ-020 SHALL, on load-use hazard, drive stall=1, bubble=1, ex_hold=0 combinationally in that cycle; exactly one stall cycle per load.
REQ-021 SHALL never flag a hazard for register 0 (guaranteed by REQ-018).
REQ-022 SHALL, on issue with id_is_mul=1, load busy counter with MUL_LAT-1 next cycle.
REQ-023 SHALL treat mul_busy = (counter!=0); counter decrements by 1 per cycle while nonzero, never wraps below 0.
REQ-024 SHALL, while mul_busy, drive stall=1, ex_hold=1, bubble=0, regardless of ID contents or flush.
REQ-025 SHALL give mul_busy priority over load-use hazard; a pending load-use stall is evaluated only after mul_busy drops.
REQ-026 SHALL, with MUL_LAT=4 and mul issued in cycle t, hold mul_busy in t+1..t+3 and allow next issue in t+4.
REQ-027 SHALL, with flush=1 and mul_busy=0, drive stall=0, bubble=0 (flushed instruction never stalls).
REQ-028 SHALL increment stall_cycles each cycle stall=1, saturating at 0xFFFF.
REQ-029 SHALL produce stall, bubble, ex_hold combinationally from registered state and current ID inputs (zero added latency).

Reset
REQ-030 SHALL, when rst_n=0 at a rising edge, clear ld_pending, ld_rd, busy counter and stall_cycles to 0, including mid-multiply.
REQ-031 SHALL drive stall=0, bubble=0, ex_hold=0 in the first cycle after reset with id_valid=0.

Structure
REQ-032 SHALL take register-index width (5), MUL_LAT default and counter widths from the shared CPU package.
REQ-033 SHALL reuse the existing reg_eq_check and zero_check blocks for register compares.
REQ-034 SHALL place the busy down-counter in one sub-module named mul_busy_timer.

Verification
REQ-035 SHALL cover: load x5 issued t, ID at t+1 reads rs=x5 -> stall=1,bubble=1 at t+1 only; stall_cycles=1.
REQ-036 SHALL cover: load x0 issued, next ID reads rs=x0 -> stall=0.
REQ-037 SHALL cover: mul issued t (MUL_LAT=4) -> stall=ex_hold=1 at t+1..t+3, 0 at t+4; stall_cycles=3.
REQ-038 SHALL cover: load x7 then dependent instruction with flush=1 at t+1 -> stall=0, bubble=0.
REQ-039 SHALL cover: rst_n=0 at t+2 of a multiply -> ex_hold=0 and stall_cycles=0 from t+3.
REQ-040 SHALL cover: 70000 forced stall cycles -> stall_cycles holds 0xFFFF.
